// File: rtl/dmem_bytelane_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bytelane_if
// Description : Request/response bundle between the core memory stage and the
//               byte-lane data memory.
//               master : requester (drives req_*, observes rsp_* / init_done)
//               slave  : memory    (drives req_ready, rsp_*, init_done)
//               Signals: req_valid, req_ready, req_we, req_funct3[2:0],
//                        req_addr[31:0], req_wdata[31:0], rsp_valid,
//                        rsp_rdata[31:0], rsp_err[1:0], init_done
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        init_done;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bytelane
// Description : Byte-addressed RV32I data memory with valid/ready requests and
//               a registered response RD_LAT cycles after accept. Supports
//               SB/SH/SW stores with lane enables and LB/LH/LW/LBU/LHU loads
//               with sign/zero extension. Flags illegal funct3, out-of-range
//               and misaligned accesses; clears its contents after reset.
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-high
//               bus   - dmem_bytelane_if.slave (request, response, init_done)
// Parameters  : DEPTH_WORDS - number of 32-bit words (power of two, >= 4)
//               RD_LAT      - response latency after accept (1..4)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bytelane #(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_bytelane_if.slave  bus
);

    localparam int                  c_ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [c_ADDR_W-1:0] c_LAST_PTR = c_ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [2:0]          c_LAT      = 3'(RD_LAT);

    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_IDLE = 2'd1;
    localparam logic [1:0] c_ST_BUSY = 2'd2;

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_ALIGN = 2'b01;
    localparam logic [1:0] c_ERR_RANGE = 2'b10;
    localparam logic [1:0] c_ERR_F3    = 2'b11;

    logic [31:0]         r_mem [DEPTH_WORDS];
    logic [1:0]          r_state;
    logic [c_ADDR_W-1:0] r_ptr;
    logic [2:0]          r_cnt;
    logic [31:0]         r_word;
    logic [1:0]          r_lane;
    logic [2:0]          r_funct3;
    logic                r_we;
    logic [1:0]          r_err;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic [1:0]          r_rsp_err;
    logic                r_init_done;

    logic                w_ready;
    logic                w_accept;
    logic [c_ADDR_W-1:0] w_idx;
    logic [1:0]          w_lane;
    logic                w_illegal;
    logic                w_oor;
    logic                w_misal;
    logic [1:0]          w_err;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata_lane;
    logic [31:0]         w_shift;
    logic [31:0]         w_load_result;

    // Gated with reset so the block never advertises readiness in a reset cycle.
    assign w_ready  = (r_state == c_ST_IDLE) && !reset;
    assign w_accept = w_ready && bus.req_valid;
    assign w_idx    = bus.req_addr[c_ADDR_W+1:2];
    assign w_lane   = bus.req_addr[1:0];

    // Request classification; priority is funct3 > range > alignment.
    assign w_illegal = bus.req_we ? (bus.req_funct3 > 3'b010)
                                  : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
    assign w_oor     = (bus.req_addr >> (c_ADDR_W + 2)) != 32'd0;
    assign w_misal   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        w_err = c_ERR_OK;
        if (w_illegal)    w_err = c_ERR_F3;
        else if (w_oor)   w_err = c_ERR_RANGE;
        else if (w_misal) w_err = c_ERR_ALIGN;
    end

    // Store data is replicated across lanes so the byte enables alone pick the
    // destination lane(s).
    always_comb begin
        w_be         = 4'b0000;
        w_wdata_lane = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                w_be         = 4'b0001 << w_lane;
                w_wdata_lane = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_lane = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                w_be         = 4'b1111;
                w_wdata_lane = bus.req_wdata;
            end
            default: begin
                w_be         = 4'b0000;
                w_wdata_lane = bus.req_wdata;
            end
        endcase
    end

    // Storage array: clear sweep during INIT, stores and load sampling at accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == c_ST_INIT) begin
                r_mem[r_ptr] <= 32'd0;
            end else if (w_accept) begin
                r_word <= r_mem[w_idx];
                if (bus.req_we && (w_err == c_ERR_OK)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_be[b]) begin
                            r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Load formatting works on the word sampled at accept; selected lane moved to bit 0.
    assign w_shift = r_word >> {r_lane, 3'b000};

    always_comb begin
        w_load_result = 32'd0;
        if (!r_we && (r_err == c_ERR_OK)) begin
            case (r_funct3)
                3'b000:  w_load_result = {{24{w_shift[7]}},  w_shift[7:0]};
                3'b001:  w_load_result = {{16{w_shift[15]}}, w_shift[15:0]};
                3'b010:  w_load_result = w_shift;
                3'b100:  w_load_result = {24'd0, w_shift[7:0]};
                3'b101:  w_load_result = {16'd0, w_shift[15:0]};
                default: w_load_result = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_INIT;
            r_ptr       <= '0;
            r_cnt       <= 3'd0;
            r_lane      <= 2'b00;
            r_funct3    <= 3'b000;
            r_we        <= 1'b0;
            r_err       <= c_ERR_OK;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= c_ERR_OK;
            r_init_done <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_INIT: begin
                    if (r_ptr == c_LAST_PTR) begin
                        r_state     <= c_ST_IDLE;
                        r_init_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_lane   <= w_lane;
                        r_funct3 <= bus.req_funct3;
                        r_we     <= bus.req_we;
                        r_err    <= w_err;
                        r_cnt    <= c_LAT;
                        r_state  <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    // Response is registered on the edge where the count expires,
                    // so it is visible in the first IDLE cycle.
                    if (r_cnt <= 3'd1) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load_result;
                        r_rsp_err   <= r_err;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_INIT;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bytelane
// Description : Scoreboard bench for dmem_bytelane (DEPTH_WORDS=16, RD_LAT=3).
//               Stimulus pushes expected responses; a negedge monitor pops and
//               compares data, error code and accept-to-response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bytelane;

    localparam int DEPTH = 16;
    localparam int LAT   = 3;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_bytelane_if bus();

    dmem_bytelane #(.DEPTH_WORDS(DEPTH), .RD_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        longint      acc;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;
    longint last_acc = 0;
    longint accs[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h, expected no response", bus.rsp_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata",   bus.rsp_rdata,       e.rdata);
                chk("rsp_err",     32'(bus.rsp_err),    32'(e.err));
                chk("rsp_latency", 32'(cyc - e.acc),    32'(LAT));
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic [1:0] exp_err, input bit hold);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 after %0d cycles, expected 1", n);
            bus.req_valid = 1'b0;
            return;
        end
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.acc    = cyc + 1;
        last_acc = e.acc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got %0d responses missing, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] data, input logic [1:0] err);
        issue(1'b1, f3, addr, data, 32'd0, err, 1'b0);
        drain();
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp, input logic [1:0] err);
        issue(1'b0, f3, addr, 32'd0, exp, err, 1'b0);
        drain();
    endtask

    task automatic do_reset();
        int n = 0;
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("reset_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("reset_init_done", 32'(bus.init_done), 32'd0);
        reset = 1'b0;
        while (!bus.req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("init_cycles", 32'(n), 32'(DEPTH));
        chk("init_done",   32'(bus.init_done), 32'd1);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        do_reset();

        // Fill every word, then reset: the sweep must zero all of them.
        for (int i = 0; i < DEPTH; i++) st(F_W, 32'(4*i), 32'hA500_0000 | 32'(i), 2'b00);
        do_reset();
        for (int i = 0; i < DEPTH; i++) ld(F_W, 32'(4*i), 32'd0, 2'b00);

        // Byte lanes
        st(F_W,  32'h8, 32'h1122_3344, 2'b00);
        st(F_B,  32'hA, 32'h0000_00AA, 2'b00);
        ld(F_W,  32'h8, 32'h11AA_3344, 2'b00);
        ld(F_B,  32'hA, 32'hFFFF_FFAA, 2'b00);
        ld(F_BU, 32'hA, 32'h0000_00AA, 2'b00);

        // Half-word extension, lower half preserved
        st(F_W,  32'h4, 32'h5566_7788, 2'b00);
        st(F_H,  32'h6, 32'h0000_8001, 2'b00);
        ld(F_H,  32'h6, 32'hFFFF_8001, 2'b00);
        ld(F_HU, 32'h6, 32'h0000_8001, 2'b00);
        ld(F_W,  32'h4, 32'h8001_7788, 2'b00);
        ld(F_HU, 32'h4, 32'h0000_7788, 2'b00);

        // Errors and priority
        st(F_W,    32'h0,  32'h0102_0304, 2'b00);
        st(F_H,    32'h3,  32'h0000_BEEF, 2'b01);
        ld(F_W,    32'h0,  32'h0102_0304, 2'b00);
        ld(F_W,    32'h5,  32'h0,         2'b01);
        ld(F_W,    32'h40, 32'h0,         2'b10);
        ld(3'b111, 32'h0,  32'h0,         2'b11);
        st(3'b011, 32'h0,  32'hFFFF_FFFF, 2'b11);
        ld(F_W,    32'h0,  32'h0102_0304, 2'b00);
        ld(3'b111, 32'h41, 32'h0,         2'b11);
        ld(F_H,    32'h41, 32'h0,         2'b10);
        ld(F_BU,   32'h3,  32'h0000_0001, 2'b00);

        // Top-of-memory boundary
        st(F_W, 32'h3C, 32'h8000_0000, 2'b00);
        ld(F_B, 32'h3F, 32'hFFFF_FF80, 2'b00);
        ld(F_H, 32'h3E, 32'hFFFF_8000, 2'b00);

        // Back-to-back loads with req_valid held high
        issue(1'b0, F_W, 32'h0, 32'd0, 32'h0102_0304, 2'b00, 1'b1); accs[0] = last_acc;
        issue(1'b0, F_W, 32'h4, 32'd0, 32'h8001_7788, 2'b00, 1'b1); accs[1] = last_acc;
        issue(1'b0, F_W, 32'h8, 32'd0, 32'h11AA_3344, 2'b00, 1'b1); accs[2] = last_acc;
        issue(1'b0, F_W, 32'hC, 32'd0, 32'h0,         2'b00, 1'b0); accs[3] = last_acc;
        drain();
        for (int i = 1; i < 4; i++) chk("accept_spacing", 32'(accs[i] - accs[i-1]), 32'(LAT + 1));

        // Reset while BUSY: pending response is dropped, sweep clears the store
        issue(1'b1, F_W, 32'h0, 32'hDEAD_BEEF, 32'd0, 2'b00, 1'b0);
        do_reset();
        repeat (8) @(negedge clk);
        ld(F_W, 32'h0, 32'd0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_bytelane.md
# dmem_bytelane

Byte-addressed, parametrised data memory for the single-cycle/multi-cycle RISC-V datapath, with a valid/ready request interface and a registered response after a configurable read latency. It performs RV32I byte, half and word stores with lane selection and loads with sign or zero extension. It detects misaligned, out-of-range and illegal-funct3 accesses, and clears its contents with a hardware init sweep after reset. It sits between the core's memory stage and its writeback mux, replacing the fixed 1024-word store.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, ≥ 4.
- RD_LAT, 1: response latency in cycles after accept, range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes are used for SB and SH.
- rsp_valid  out  1  one-cycle pulse marking a completed request.
- rsp_rdata  out  32  load result; 0 for stores and errored accesses.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3.
- init_done  out  1  high once the clear sweep has finished.

## Operation
- FSM states: INIT, IDLE, BUSY.
- INIT: a word pointer runs from 0 to DEPTH_WORDS-1 and writes 0 to one word per cycle. Leaves INIT to IDLE after the last word; init_done then rises and stays high until the next reset.
- IDLE: req_ready=1. Accept occurs when req_valid && req_ready at a rising edge; the request fields are captured and the FSM moves to BUSY with a latency counter loaded to RD_LAT.
- BUSY: req_ready=0. The counter decrements each cycle; when it expires, a registered rsp_valid pulse is issued and the FSM returns to IDLE.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]; lane = req_addr[1:0].
- Stores are committed at the accept edge:
  - SB writes lane addr[1:0] only.
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- Loads sample memory at the accept edge. The selected lane(s) are shifted to bit 0; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend.
- Error priority is illegal funct3 > out-of-range > misaligned.
  - Illegal funct3: stores with 011..111; loads with 011, 110, 111.
  - Out-of-range: req_addr ≥ 4*DEPTH_WORDS.
  - Misaligned: H access with addr[0]=1, or W access with addr[1:0]≠0.
- An errored access writes nothing, returns rsp_rdata=0, and still completes with rsp_valid after RD_LAT cycles.
- Stores also produce an rsp_valid acknowledgement with rsp_rdata=0.
- Only one request is outstanding at a time, so a load issued after a store's response always returns the stored data.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, init_done=0. FSM goes to INIT with the pointer at 0.
- INIT lasts exactly DEPTH_WORDS cycles after reset deasserts. req_ready first goes high in the cycle after the last clear write.
- Accept at edge E0 → rsp_valid is high in the cycle after edge E(RD_LAT), for exactly one cycle.
- rsp_rdata and rsp_err are valid only while rsp_valid=1. They hold their value otherwise and are not cleared between responses.
- req_ready is high in the rsp_valid cycle, so the next accept can occur at the edge ending it. Sustained throughput is one request per RD_LAT+1 cycles.
- The requester must hold the request fields stable while req_valid=1 && req_ready=0. The block does not drop or reorder requests.
- Reset in BUSY aborts the pending response; no rsp_valid is produced for it. A store already committed at its accept edge is then cleared by the INIT sweep.
- Reset in INIT restarts the sweep from word 0.
- No memory write takes place in the reset cycle itself.

## Test plan
- Init: assert reset for 2 cycles, then release with DEPTH_WORDS=16 → req_ready rises exactly 16 cycles later, init_done=1, and LW from any of the 16 words returns 0.
- Byte lanes: SW 0x11223344 to 0x8, then SB 0xAA to 0xA, then LW 0x8 → 0x11AA3344. Then LB 0xA → 0xFFFFFFAA and LBU 0xA → 0x000000AA.
- Half extension: SH 0x8001 to 0x6, then LH 0x6 → 0xFFFF8001 and LHU 0x6 → 0x00008001. The lower half of word 1 is unchanged.
- Errors:
  - LW 0x5 → rsp_err=01, rdata=0.
  - SH 0x3 → rsp_err=01, memory unchanged.
  - LW 0x40 with DEPTH_WORDS=16 → rsp_err=10.
  - Load with funct3=111 → rsp_err=11.
- Latency and back-to-back: with RD_LAT=3 and req_valid held high over 4 LW requests → each rsp_valid arrives 3 cycles after its accept, accepts are spaced 4 cycles apart, and no response is lost or duplicated.
- Reset mid-operation: SW 0xDEADBEEF to 0x0, then assert reset in the next cycle (BUSY) → no rsp_valid is produced. After init_done, LW 0x0 returns 0.
